// File: rtl/score_pkg.sv
// Shared FSM state type and default timing/score constants for the scoreboard controller.
// Pure declarations; no logic, no latency, no flow control.
package score_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int HOLD_CYCLES_1S = CLK_HZ;
  localparam int DEBOUNCE_10MS  = CLK_HZ / 100;
  localparam int MAX_SCORE_DEF  = 99;

  typedef enum logic [1:0] {
    RUN,
    CLR_HOLD,
    CLR_WAIT_REL
  } clr_state_t;

endpackage

// File: rtl/score_ctrl_if.sv
// Button inputs and score/status outputs of the scoreboard controller.
// Master drives the buttons, slave (the controller) drives scores and clear status.
interface score_ctrl_if #(
  parameter int SCORE_W = 7
);

  logic               btn_a_n;
  logic               btn_b_n;
  logic               btn_clr_n;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic               clr_busy;
  logic               clr_done;

  modport master (
    output btn_a_n, btn_b_n, btn_clr_n,
    input  score_a, score_b, clr_busy, clr_done
  );

  modport slave (
    input  btn_a_n, btn_b_n, btn_clr_n,
    output score_a, score_b, clr_busy, clr_done
  );

endinterface

// File: rtl/score_ctrl_btn_conditioner.sv
// Button synchroniser, optional debounce (SCORE_CTRL_DEBOUNCE_EN) and falling-edge press pulse.
// Pulse SYNC_STAGES clocks after the pin (+DEBOUNCE_CYCLES when debounced); no backpressure.
module btn_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_n;
  logic                   filt_n;
  logic                   prev_n;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_conditioner: SYNC_STAGES must be at least 2");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign synced_n = sync_q[SYNC_STAGES-1];

`ifdef SCORE_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  // Counter measures how long the synced level has disagreed with the filtered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_q   <= 1'b1;
    end else if (synced_n == db_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      db_q   <= synced_n;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign filt_n = db_q;
`else
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  assign filt_n = synced_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_n <= 1'b1;
    end else begin
      prev_n <= filt_n;
    end
  end

  assign level       = ~filt_n;
  assign press_pulse = prev_n & ~filt_n;

endmodule

// File: rtl/score_ctrl.sv
// Scoreboard sequencer: conditions A/B/clear buttons, arbitrates increments, applies long-hold clear.
// Score updates SYNC_STAGES+1 clocks after the pin (+DEBOUNCE_CYCLES with SCORE_CTRL_DEBOUNCE_EN); no backpressure.
module score_ctrl
  import score_pkg::*;
#(
  parameter int HOLD_CYCLES     = HOLD_CYCLES_1S,
  parameter int MAX_SCORE       = MAX_SCORE_DEF,
  parameter int SCORE_W         = 7,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic       clk,
  input  logic       rst_n,
  score_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("score_ctrl: HOLD_CYCLES must be at least 2");
  end
  if ((2 ** SCORE_W) <= MAX_SCORE) begin : g_bad_width
    $error("score_ctrl: SCORE_W too narrow for MAX_SCORE");
  end

  logic a_level, a_press;
  logic b_level, b_press;
  logic clr_level, clr_press;
  logic unused_cond;

  clr_state_t         state, state_nx;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [SCORE_W-1:0] score_a_q, score_a_nx;
  logic [SCORE_W-1:0] score_b_q, score_b_nx;
  logic               pending_b, pending_b_nx;
  logic               clr_done_q, clr_done_nx;

  btn_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (bus.btn_a_n),
    .level      (a_level),
    .press_pulse(a_press)
  );

  btn_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (bus.btn_b_n),
    .level      (b_level),
    .press_pulse(b_press)
  );

  btn_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (bus.btn_clr_n),
    .level      (clr_level),
    .press_pulse(clr_press)
  );

  // Increments are edge-driven and the clear is level-driven; the other outputs are not needed.
  assign unused_cond = ^{a_level, b_level, clr_press};

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s < SCORE_MAX) ? s + 1'b1 : SCORE_MAX;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      hold_cnt   <= '0;
      score_a_q  <= '0;
      score_b_q  <= '0;
      pending_b  <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= hold_cnt_nx;
      score_a_q  <= score_a_nx;
      score_b_q  <= score_b_nx;
      pending_b  <= pending_b_nx;
      clr_done_q <= clr_done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = hold_cnt;
    score_a_nx   = score_a_q;
    score_b_nx   = score_b_q;
    pending_b_nx = pending_b;
    clr_done_nx  = 1'b0;

    unique case (state)
      RUN: begin
        if (a_press) begin
          score_a_nx = sat_inc(score_a_q);
        end
        // A wins a tie; B is deferred one cycle through pending_b, and a B press
        // landing on a pending cycle is re-latched so neither is lost.
        if (pending_b || (b_press && !a_press)) begin
          score_b_nx = sat_inc(score_b_q);
        end
        pending_b_nx = b_press && (a_press || pending_b);
        if (clr_level) begin
          state_nx    = CLR_HOLD;
          hold_cnt_nx = '0;
        end
      end

      CLR_HOLD: begin
        if (!clr_level) begin
          state_nx    = RUN;
          hold_cnt_nx = '0;
        end else if (hold_cnt == CNT_LAST) begin
          state_nx     = CLR_WAIT_REL;
          hold_cnt_nx  = '0;
          score_a_nx   = '0;
          score_b_nx   = '0;
          pending_b_nx = 1'b0;
          clr_done_nx  = 1'b1;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end

      CLR_WAIT_REL: begin
        if (!clr_level) begin
          state_nx = RUN;
        end
      end

      default: begin
        state_nx    = RUN;
        hold_cnt_nx = '0;
      end
    endcase
  end

  assign bus.score_a  = score_a_q;
  assign bus.score_b  = score_b_q;
  assign bus.clr_busy = (state == CLR_HOLD);
  assign bus.clr_done = clr_done_q;

endmodule
